// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared state, opcode and strobe encodings for the RISC control FSM
package risc_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_MOVI, S_GETA, S_GETB, S_ALU,
    S_WB, S_ADDR, S_LADDR, S_RD1, S_RD2, S_SGETD, S_SALU, S_SWR, S_HALT
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_HLT = 3'b111;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MEM  = 2'b00;

  localparam logic [2:0] NSEL_RM = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RN = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/risc_control_fsm.sv
// rtl/risc_control_fsm.sv - multi-cycle Moore control FSM sequencing fetch/decode/execute/writeback
module risc_control_fsm
  import risc_pkg::*;
#(
  parameter bit UNDEF_IS_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  state_t state, state_nx;
  // Remembers LDR vs STR past S_GETA so S_LADDR can branch without looking at opcode.
  logic   is_str;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RST;
      is_str <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_GETA) is_str <= (opcode == OPC_STR);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RST: state_nx = S_IF1;
      S_IF1: state_nx = S_IF2;
      S_IF2: state_nx = S_UPC;
      S_UPC: state_nx = S_DEC;
      S_DEC: begin
        state_nx = UNDEF_IS_NOP ? S_IF1 : S_HALT;
        case (opcode)
          OPC_MOV: begin
            if (op == OP_MOVI)      state_nx = S_MOVI;
            else if (op == OP_MOVR) state_nx = S_GETB;
          end
          OPC_ALU: state_nx = (op == OP_MVN) ? S_GETB : S_GETA;
          OPC_LDR: if (op == OP_MEM) state_nx = S_GETA;
          OPC_STR: if (op == OP_MEM) state_nx = S_GETA;
          OPC_HLT: state_nx = S_HALT;
          default: ;
        endcase
      end
      S_GETA:  state_nx = (opcode == OPC_ALU) ? S_GETB : S_ADDR;
      S_GETB:  state_nx = S_ALU;
      S_ALU:   state_nx = (opcode == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WB;
      S_ADDR:  state_nx = S_LADDR;
      S_LADDR: state_nx = is_str ? S_SGETD : S_RD1;
      S_RD1:   state_nx = S_RD2;
      S_SGETD: state_nx = S_SALU;
      S_SALU:  state_nx = S_SWR;
      S_MOVI, S_WB, S_RD2, S_SWR: state_nx = S_IF1;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    nsel      = 3'b000;
    vsel      = VSEL_C;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPC: load_pc = 1'b1;
      S_MOVI: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      S_GETA: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        // Register moves pass B through the ALU by zeroing A.
        asel  = (opcode == OPC_MOV) || (opcode == OPC_ALU && op == OP_MVN);
        loads = (opcode == OPC_ALU && op == OP_CMP);
      end
      S_WB: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LADDR: load_addr = 1'b1;
      S_RD1:   mem_cmd = MEM_READ;
      S_RD2: begin
        mem_cmd = MEM_READ;
        nsel    = NSEL_RD;
        vsel    = VSEL_MDATA;
        write   = 1'b1;
      end
      S_SGETD: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      S_SALU: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_SWR:  mem_cmd = MEM_WRITE;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_control_fsm.sv
// tb/tb_risc_control_fsm.sv - table-driven scoreboard bench for risc_control_fsm
module tb_risc_control_fsm;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } ov_t;

  typedef enum logic [4:0] {
    T_END, T_RST, T_IF1, T_IF2, T_UPC, T_DEC, T_MOVI, T_GETA, T_GETB,
    T_ALU, T_ALU_M, T_ALU_C, T_WB, T_ADDR, T_LADDR, T_RD1, T_RD2,
    T_SGETD, T_SALU, T_SWR, T_HALT
  } tst_t;

  typedef struct {
    logic [2:0]       opc;
    logic [1:0]       op;
    string            name;
    int               lat;
    logic [0:9][4:0]  seq;
  } vec_t;

  typedef struct {
    ov_t   v;
    string tag;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] opcode;
  logic [1:0] op;

  logic [2:0] nsel;
  logic [1:0] vsel, mem_cmd;
  logic write, loada, loadb, loadc, loads, asel, bsel;
  logic load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;

  logic [2:0] h_nsel;
  logic [1:0] h_vsel, h_mem_cmd;
  logic h_write, h_loada, h_loadb, h_loadc, h_loads, h_asel, h_bsel;
  logic h_load_ir, h_load_pc, h_reset_pc, h_addr_sel, h_load_addr, h_halted;

  ov_t act;
  assign act = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

  risc_control_fsm #(.UNDEF_IS_NOP(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel),
    .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
  );

  risc_control_fsm #(.UNDEF_IS_NOP(1'b0)) dut_h (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(h_nsel), .vsel(h_vsel), .write(h_write), .loada(h_loada), .loadb(h_loadb),
    .loadc(h_loadc), .loads(h_loads), .asel(h_asel), .bsel(h_bsel), .load_ir(h_load_ir),
    .load_pc(h_load_pc), .reset_pc(h_reset_pc), .addr_sel(h_addr_sel),
    .load_addr(h_load_addr), .mem_cmd(h_mem_cmd), .halted(h_halted)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  sb_t sbq[$];
  vec_t tbl[8];

  function automatic ov_t exp_of(input tst_t s);
    ov_t o;
    o = '0;
    case (s)
      T_RST:   begin o.reset_pc = 1; o.load_pc = 1; end
      T_IF1:   begin o.addr_sel = 1; o.mem_cmd = 2'b01; end
      T_IF2:   begin o.addr_sel = 1; o.mem_cmd = 2'b01; o.load_ir = 1; end
      T_UPC:   o.load_pc = 1;
      T_MOVI:  begin o.nsel = 3'b100; o.vsel = 2'b10; o.write = 1; end
      T_GETA:  begin o.nsel = 3'b100; o.loada = 1; end
      T_GETB:  begin o.nsel = 3'b001; o.loadb = 1; end
      T_ALU:   o.loadc = 1;
      T_ALU_M: begin o.loadc = 1; o.asel = 1; end
      T_ALU_C: begin o.loadc = 1; o.loads = 1; end
      T_WB:    begin o.nsel = 3'b010; o.vsel = 2'b00; o.write = 1; end
      T_ADDR:  begin o.bsel = 1; o.loadc = 1; end
      T_LADDR: o.load_addr = 1;
      T_RD1:   o.mem_cmd = 2'b01;
      T_RD2:   begin o.mem_cmd = 2'b01; o.nsel = 3'b010; o.vsel = 2'b11; o.write = 1; end
      T_SGETD: begin o.nsel = 3'b010; o.loadb = 1; end
      T_SALU:  begin o.asel = 1; o.loadc = 1; end
      T_SWR:   o.mem_cmd = 2'b10;
      T_HALT:  o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [19:0] a, input logic [19:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %05h expected %05h", tag, a, e);
    end
  endtask

  task automatic check_int(input string tag, input int a, input int e);
    compared++;
    if (a != e) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, a, e);
    end
  endtask

  task automatic push_seq(input string name, input logic [0:9][4:0] seq);
    sb_t e;
    for (int i = 0; i < 10; i++) begin
      if (seq[i] != T_END) begin
        e.v   = exp_of(tst_t'(seq[i]));
        e.tag = $sformatf("%s[%0d]", name, i);
        sbq.push_back(e);
      end
    end
  endtask

  // One popped entry per cycle; also records when the fetch signature reappears.
  task automatic drain(output int lat);
    sb_t e;
    int  n;
    n   = 0;
    lat = -1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, act, e.v);
      @(negedge clk);
      n++;
      if (lat < 0 && addr_sel && mem_cmd == 2'b01 && !load_ir) lat = n;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0] = '{3'b110, 2'b10, "MOVI", 5, {T_IF1, T_IF2, T_UPC, T_DEC, T_MOVI, T_END, T_END, T_END, T_END, T_END}};
    tbl[1] = '{3'b110, 2'b00, "MOVR", 7, {T_IF1, T_IF2, T_UPC, T_DEC, T_GETB, T_ALU_M, T_WB, T_END, T_END, T_END}};
    tbl[2] = '{3'b101, 2'b11, "MVN",  7, {T_IF1, T_IF2, T_UPC, T_DEC, T_GETB, T_ALU_M, T_WB, T_END, T_END, T_END}};
    tbl[3] = '{3'b101, 2'b00, "ADD",  8, {T_IF1, T_IF2, T_UPC, T_DEC, T_GETA, T_GETB, T_ALU, T_WB, T_END, T_END}};
    tbl[4] = '{3'b101, 2'b01, "CMP",  7, {T_IF1, T_IF2, T_UPC, T_DEC, T_GETA, T_GETB, T_ALU_C, T_END, T_END, T_END}};
    tbl[5] = '{3'b101, 2'b10, "AND",  8, {T_IF1, T_IF2, T_UPC, T_DEC, T_GETA, T_GETB, T_ALU, T_WB, T_END, T_END}};
    tbl[6] = '{3'b011, 2'b00, "LDR",  9, {T_IF1, T_IF2, T_UPC, T_DEC, T_GETA, T_ADDR, T_LADDR, T_RD1, T_RD2, T_END}};
    tbl[7] = '{3'b100, 2'b00, "STR", 10, {T_IF1, T_IF2, T_UPC, T_DEC, T_GETA, T_ADDR, T_LADDR, T_SGETD, T_SALU, T_SWR}};

    reset  = 1'b1;
    opcode = 3'b000;
    op     = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check("reset_state", act, exp_of(T_RST));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      opcode = tbl[i].opc;
      op     = tbl[i].op;
      push_seq(tbl[i].name, tbl[i].seq);
      drain(lat);
      check_int({tbl[i].name, "_latency"}, lat, tbl[i].lat);
    end

    // Reset arriving mid-load must abandon the memory read immediately.
    opcode = 3'b011;
    op     = 2'b00;
    push_seq("LDR_pre", {T_IF1, T_IF2, T_UPC, T_DEC, T_GETA, T_ADDR, T_LADDR, T_END, T_END, T_END});
    drain(lat);
    check("rd1_state", act, exp_of(T_RD1));
    reset = 1'b1;
    @(negedge clk);
    check("reset_from_rd1", act, exp_of(T_RST));
    check_int("reset_from_rd1_memcmd", int'(mem_cmd), 0);
    reset = 1'b0;
    @(negedge clk);

    opcode = 3'b111;
    op     = 2'b00;
    push_seq("HLT", {T_IF1, T_IF2, T_UPC, T_DEC, T_END, T_END, T_END, T_END, T_END, T_END});
    drain(lat);
    for (int c = 0; c < 20; c++) begin
      check($sformatf("halt_hold[%0d]", c), act, exp_of(T_HALT));
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check("reset_from_halt", act, exp_of(T_RST));
    reset = 1'b0;
    @(negedge clk);

    opcode = 3'b000;
    op     = 2'b00;
    push_seq("UNDEF", {T_IF1, T_IF2, T_UPC, T_DEC, T_END, T_END, T_END, T_END, T_END, T_END});
    drain(lat);
    check("undef_nop_refetch", act, exp_of(T_IF1));
    check_int("undef_halt_variant", int'(h_halted), 1);
    check_int("undef_halt_variant_memcmd", int'(h_mem_cmd), 0);
    @(negedge clk);
    check_int("undef_halt_variant_hold", int'(h_halted), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/risc_control_fsm.md
Name: risc_control_fsm

Overview:
Multi-cycle control state machine for the memory-interfaced RISC datapath. It sits directly downstream of the instruction decoder and consumes its opcode/op fields. It drives the decoder's one-hot nsel and every datapath, PC, IR, address-register and memory-command strobe. It sequences fetch, decode, execute and writeback for MOV, ALU, LDR, STR and HALT.

Parameters:
UNDEF_IS_NOP, 1, 1: an undefined opcode/op returns to S_IF1 as a NOP; 0: it enters S_HALT.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high; forces S_RST on the next clk edge.
opcode  input  3  instruction[15:13], from the decoder.
op  input  2  instruction[12:11], from the decoder.
nsel  output  3  one-hot register select: 001 Rm, 010 Rd, 100 Rn, 000 idle.
vsel  output  2  writeback mux: 00 C, 01 PC, 10 sximm8, 11 mdata.
write  output  1  register-file write enable.
loada, loadb, loadc, loads  output  1 each  A, B, C and status register loads.
asel  output  1  1 forces the ALU A input to 0.
bsel  output  1  1 selects sximm5 for the ALU B input.
load_ir  output  1  instruction register load.
load_pc  output  1  PC load.
reset_pc  output  1  PC next value = 0 (else PC+1).
addr_sel  output  1  1 selects PC as the memory address; 0 selects the data address register.
load_addr  output  1  data address register load (from C).
mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE.
halted  output  1  high in S_HALT.

Behaviour:
- Moore machine. Outputs decode from the state register only. Any output not listed for a state is 0; nsel defaults to 000 and mem_cmd to NONE.
- Reset:
  - reset=1 at an edge loads S_RST from any state, including mid-instruction and S_HALT.
  - In S_RST: reset_pc=1, load_pc=1, all other outputs 0.
- Fetch path:
  - S_RST -> S_IF1.
  - S_IF1: addr_sel=1, mem_cmd=READ -> S_IF2.
  - S_IF2: addr_sel=1, mem_cmd=READ, load_ir=1 -> S_UPC.
  - S_UPC: load_pc=1 (PC+1) -> S_DEC.
- S_DEC (no outputs) branches on {opcode,op}:
  - 110_10 (MOV Rn,#imm8) -> S_MOVI.
  - 110_00 (MOV Rd,Rm) -> S_GETB.
  - 101_11 (MVN) -> S_GETB.
  - 101_00/01/10 (ADD/CMP/AND) -> S_GETA.
  - 011_00 (LDR) and 100_00 (STR) -> S_GETA.
  - 111_xx -> S_HALT.
  - Anything else -> per UNDEF_IS_NOP.
- Execute states:
  - S_MOVI: nsel=100, vsel=10, write=1 -> S_IF1.
  - S_GETA: nsel=100, loada=1 -> S_GETB for ALU ops; S_ADDR for LDR/STR.
  - S_GETB: nsel=001, loadb=1 -> S_ALU.
  - S_ALU: loadc=1; asel=1 for MOV/MVN; loads=1 only for CMP. CMP -> S_IF1; others -> S_WB.
  - S_WB: nsel=010, vsel=00, write=1 -> S_IF1.
- Memory states:
  - S_ADDR: bsel=1, loadc=1 -> S_LADDR.
  - S_LADDR: load_addr=1 -> S_RD1 for LDR; S_SGETD for STR.
  - S_RD1: addr_sel=0, mem_cmd=READ -> S_RD2.
  - S_RD2: mem_cmd=READ, nsel=010, vsel=11, write=1 -> S_IF1.
  - S_SGETD: nsel=010, loadb=1 -> S_SALU.
  - S_SALU: asel=1, loadc=1 -> S_SWR.
  - S_SWR: addr_sel=0, mem_cmd=WRITE -> S_IF1.
- S_HALT: halted=1, all strobes 0. Self-loops until reset.
- Instruction latency, counted from S_IF1 up to the next S_IF1:
  - MOVI: 5 cycles.
  - MOV reg, MVN, CMP: 7 cycles.
  - ADD, AND: 8 cycles.
  - LDR: 9 cycles.
  - STR: 10 cycles.
- opcode/op are sampled only in S_DEC, S_GETA and S_ALU. The IR is stable there, so no input registering is needed.
- Never assert write and mem_cmd=WRITE in the same state. Never assert more than one nsel bit.

Decomposition:
- Shared package risc_pkg holds:
  - state enum state_t.
  - opcode constants OPC_MOV=110, OPC_ALU=101, OPC_LDR=011, OPC_STR=100, OPC_HLT=111.
  - nsel constants NSEL_RM/RD/RN.
  - vsel constants VSEL_C/PC/IMM8/MDATA.
  - mem_cmd constants MEM_NONE/READ/WRITE.
- No sub-module. The next-state and output decode live as two always_comb blocks beside one always_ff state register.

Test Plan:
- Reset with reset=1 for 1 cycle from any state -> S_RST with reset_pc=1, load_pc=1, then S_IF1 with mem_cmd=01, addr_sel=1.
- MOVI: opcode=110, op=10 -> 5-cycle sequence; S_MOVI shows nsel=100, vsel=10, write=1; back to S_IF1.
- ADD: opcode=101, op=00 -> GETA (nsel=100, loada) then GETB (nsel=001, loadb) then ALU (loadc, loads=0) then WB (nsel=010, vsel=00, write); 8 cycles total. CMP (op=01) -> loads=1, no write, 7 cycles.
- LDR then STR (011_00, 100_00) -> LDR RD2 shows mem_cmd=01, vsel=11, write=1. STR SWR shows mem_cmd=10, addr_sel=0, write=0. 9 and 10 cycles.
- HALT: opcode=111 -> halted=1 held for 20 cycles with no strobes. reset=1 -> S_RST.
- Reset asserted in S_RD1 -> next state S_RST, mem_cmd=00. Undefined 000_00 with UNDEF_IS_NOP=1 -> S_IF1 after S_DEC; with 0 -> S_HALT.
